// File: rtl/rom_port_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM: round-robin with bounded burst lock,
// combinational memory-port drive, and read-return routing through a tag pipeline.
module rom_port_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 16,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [DW-1:0]    wdata0,
  input  logic [DW-1:0]    wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [DW-1:0]    rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_din,
  input  logic [DW-1:0]    mem_dout,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  conflict_q, conflict_d;
  logic              gnt0_c, gnt1_c;
  logic              held_off_c;
  logic              rd_issue_c;
  logic              rd_id_c;
  logic [RD_LAT-1:0] tag_v_q;
  logic [RD_LAT-1:0] tag_id_q;

  // Owner FSM next state and grant decision
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    unique case (state_q)
      ST_NONE: begin
        if (req0 && req1) begin
          gnt0_c = last_q;
          gnt1_c = !last_q;
        end else begin
          gnt0_c = req0;
          gnt1_c = req1;
        end
        if (gnt0_c) begin
          state_d = ST_OWN0;
          burst_d = BURST_ONE;
        end else if (gnt1_c) begin
          state_d = ST_OWN1;
          burst_d = BURST_ONE;
        end
      end
      ST_OWN0: begin
        if (req0 && (burst_q < BURST_MAX)) begin
          gnt0_c  = 1'b1;
          burst_d = burst_q + BURST_ONE;
        end else if (req1) begin
          gnt1_c  = 1'b1;
          state_d = ST_OWN1;
          burst_d = BURST_ONE;
        end else if (req0) begin
          gnt0_c  = 1'b1;
          burst_d = BURST_ONE;
        end else begin
          state_d = ST_NONE;
          burst_d = '0;
        end
      end
      ST_OWN1: begin
        if (req1 && (burst_q < BURST_MAX)) begin
          gnt1_c  = 1'b1;
          burst_d = burst_q + BURST_ONE;
        end else if (req0) begin
          gnt0_c  = 1'b1;
          state_d = ST_OWN0;
          burst_d = BURST_ONE;
        end else if (req1) begin
          gnt1_c  = 1'b1;
          burst_d = BURST_ONE;
        end else begin
          state_d = ST_NONE;
          burst_d = '0;
        end
      end
      default: begin
        state_d = ST_NONE;
        burst_d = '0;
      end
    endcase
  end

  // Grants are forced low while reset is asserted so the memory port stays idle
  assign gnt0 = gnt0_c & ~rst;
  assign gnt1 = gnt1_c & ~rst;

  always_comb begin
    last_d = last_q;
    if (gnt1) begin
      last_d = 1'b1;
    end else if (gnt0) begin
      last_d = 1'b0;
    end
  end

  assign mem_en   = gnt0 | gnt1;
  assign mem_we   = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
  assign mem_addr = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign mem_din  = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  assign rd_issue_c = mem_en & ~mem_we;
  assign rd_id_c    = gnt1;

  // Saturating count of cycles in which some requester was held off
  assign held_off_c = (req0 & ~gnt0) | (req1 & ~gnt1);

  always_comb begin
    conflict_d = conflict_q;
    if (held_off_c && (conflict_q != CNT_SAT)) begin
      conflict_d = conflict_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_NONE;
      burst_q    <= '0;
      last_q     <= 1'b1;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      last_q     <= last_d;
      conflict_q <= conflict_d;
    end
  end

  // Read tag pipeline: the last stage lines up with BRAM dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q[0]  <= rd_issue_c;
      tag_id_q[0] <= rd_id_c;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  assign rvalid0      = tag_v_q[RD_LAT-1] & ~tag_id_q[RD_LAT-1];
  assign rvalid1      = tag_v_q[RD_LAT-1] &  tag_id_q[RD_LAT-1];
  assign rdata        = rst ? '0 : mem_dout;
  assign conflict_cnt = conflict_q;

endmodule
